// File: rtl/t1_pass_sched.sv
// t1_pass_sched -- per-bitplane coding-pass scheduler for the tier-1 MQ coder.
//
// Once the bit-plane coder has written a whole plane into the three
// context/decision FIFOs, this block drains them into the single MQ coder.
// The order is significance, then refinement, then cleanup. The first plane
// of a codeblock has only a cleanup pass. The block also:
//   - issues mq_init at codeblock start,
//   - issues mq_flush after the cleanup pass of the last plane,
//   - counts coding passes for tier-2,
//   - raises plane_ready once the MQ pipeline has had DRAIN_LAT cycles to settle.
//
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   cblk_start                pulse: new codeblock, aborts any plane in flight
//   plane_go, last_plane      pulse: plane written; last_plane sampled with it
//   {sig,ref,cln}_empty/ctx/d show-ahead FIFO heads
//   {sig,ref,cln}_rd          FIFO pops
//   mq_init/en/cx/d/flush     MQ coder interface
//   cur_pass                  0 idle, 1 sig, 2 ref, 3 cln
//   pass_cnt                  passes completed in this codeblock (saturating)
//   plane_ready               pulse: plane fully coded
//   busy                      scheduler not idle
//   err_overlap               sticky: plane_go arrived while busy
module t1_pass_sched #(
  parameter int DRAIN_LAT = 8,
  parameter int W_PASS    = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              cblk_start,
  input  logic              plane_go,
  input  logic              last_plane,
  input  logic              sig_empty,
  input  logic [5:0]        sig_ctx,
  input  logic              sig_d,
  output logic              sig_rd,
  input  logic              ref_empty,
  input  logic [5:0]        ref_ctx,
  input  logic              ref_d,
  output logic              ref_rd,
  input  logic              cln_empty,
  input  logic [5:0]        cln_ctx,
  input  logic              cln_d,
  output logic              cln_rd,
  output logic              mq_init,
  output logic              mq_en,
  output logic [5:0]        mq_cx,
  output logic              mq_d,
  output logic              mq_flush,
  output logic [1:0]        cur_pass,
  output logic [W_PASS-1:0] pass_cnt,
  output logic              plane_ready,
  output logic              busy,
  output logic              err_overlap
);

  localparam int            CW         = (DRAIN_LAT > 1) ? $clog2(DRAIN_LAT) : 1;
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_LAT - 1);

  typedef enum logic [2:0] {S_IDLE, S_SIG, S_REF, S_CLN, S_DRAIN} state_t;

  state_t        state, state_nxt;
  logic          first_plane;  // next plane is the codeblock's first (cleanup only)
  logic          last_q;       // last_plane latched with the accepted plane_go
  logic [CW-1:0] drain_cnt;
  logic          pass_done;    // the active pass's FIFO is dry: pass ends this cycle

  // State register
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; cblk_start overrides everything, including plane_go
  always_comb begin
    state_nxt = state;
    if (cblk_start) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:  if (plane_go)          state_nxt = first_plane ? S_CLN : S_SIG;
        S_SIG:   if (sig_empty)         state_nxt = S_REF;
        S_REF:   if (ref_empty)         state_nxt = S_CLN;
        S_CLN:   if (cln_empty)         state_nxt = S_DRAIN;
        S_DRAIN: if (drain_cnt == '0)   state_nxt = S_IDLE;
        default:                        state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic: pop the active FIFO whenever it has a head and forward that
  // head to the MQ coder; the symbol bus is held at zero between symbols.
  // NOTE: every signal gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    sig_rd    = 1'b0;
    ref_rd    = 1'b0;
    cln_rd    = 1'b0;
    mq_cx     = '0;
    mq_d      = 1'b0;
    cur_pass  = 2'd0;
    pass_done = 1'b0;
    case (state)
      S_SIG: begin
        cur_pass  = 2'd1;
        sig_rd    = !sig_empty;
        pass_done = sig_empty;
        if (!sig_empty) {mq_cx, mq_d} = {sig_ctx, sig_d};
      end
      S_REF: begin
        cur_pass  = 2'd2;
        ref_rd    = !ref_empty;
        pass_done = ref_empty;
        if (!ref_empty) {mq_cx, mq_d} = {ref_ctx, ref_d};
      end
      S_CLN: begin
        cur_pass  = 2'd3;
        cln_rd    = !cln_empty;
        pass_done = cln_empty;
        if (!cln_empty) {mq_cx, mq_d} = {cln_ctx, cln_d};
      end
      default: ;
    endcase
  end

  assign mq_en       = sig_rd | ref_rd | cln_rd;
  assign busy        = (state != S_IDLE);
  assign plane_ready = (state == S_DRAIN) && (drain_cnt == '0);
  // The counter is at its load value only in the first DRAIN cycle
  assign mq_flush    = (state == S_DRAIN) && (drain_cnt == DRAIN_LOAD) && last_q;

  // Bookkeeping registers
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq_init     <= 1'b0;
      pass_cnt    <= '0;
      first_plane <= 1'b1;
      last_q      <= 1'b0;
      err_overlap <= 1'b0;
      drain_cnt   <= '0;
    end else begin
      mq_init <= cblk_start;
      if (cblk_start) begin
        pass_cnt    <= '0;
        first_plane <= 1'b1;
        err_overlap <= 1'b0;
        drain_cnt   <= '0;
      end else begin
        if (plane_go && state != S_IDLE) err_overlap <= 1'b1;
        if (plane_go && state == S_IDLE) last_q <= last_plane;
        if (pass_done && pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
        if (state == S_CLN && cln_empty) begin
          first_plane <= 1'b0;
          drain_cnt   <= DRAIN_LOAD;
        end else if (state == S_DRAIN && drain_cnt != '0) begin
          drain_cnt <= drain_cnt - 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_t1_pass_sched.sv
// Self-checking bench for t1_pass_sched. The FIFOs are modelled as queues with
// random contents. Expected results come from the plane-level rules:
//   - symbol order is sig, then ref, then cln,
//   - a plane takes (cleanup-only ? nc+1 : ns+nr+nc+3) pass cycles plus DRAIN_LAT,
//   - pass count grows by 1 for the first plane, then by 3, and saturates.
module tb_t1_pass_sched;
  localparam int DRAIN_LAT = 8;
  localparam int W_PASS    = 8;
  localparam int PASS_MAX  = (1 << W_PASS) - 1;

  logic clk = 1'b0;
  logic rstn, cblk_start, plane_go, last_plane;
  logic sig_empty, sig_d, sig_rd, ref_empty, ref_d, ref_rd, cln_empty, cln_d, cln_rd;
  logic [5:0] sig_ctx, ref_ctx, cln_ctx, mq_cx;
  logic mq_init, mq_en, mq_d, mq_flush, plane_ready, busy, err_overlap;
  logic [1:0] cur_pass;
  logic [W_PASS-1:0] pass_cnt;

  always #5 clk = ~clk;

  t1_pass_sched #(.DRAIN_LAT(DRAIN_LAT), .W_PASS(W_PASS)) dut (
    .clk(clk), .rstn(rstn), .cblk_start(cblk_start), .plane_go(plane_go),
    .last_plane(last_plane),
    .sig_empty(sig_empty), .sig_ctx(sig_ctx), .sig_d(sig_d), .sig_rd(sig_rd),
    .ref_empty(ref_empty), .ref_ctx(ref_ctx), .ref_d(ref_d), .ref_rd(ref_rd),
    .cln_empty(cln_empty), .cln_ctx(cln_ctx), .cln_d(cln_d), .cln_rd(cln_rd),
    .mq_init(mq_init), .mq_en(mq_en), .mq_cx(mq_cx), .mq_d(mq_d), .mq_flush(mq_flush),
    .cur_pass(cur_pass), .pass_cnt(pass_cnt), .plane_ready(plane_ready),
    .busy(busy), .err_overlap(err_overlap)
  );

  logic [6:0] sig_q[$], ref_q[$], cln_q[$], got_q[$];
  int checks = 0, errors = 0;
  int n_init = 0, n_flush = 0, n_ready = 0, n_rd = 0;
  logic ready_s, flush_s;
  logic [1:0] cur_s;
  int pcnt_m;
  bit first_m;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present the queue heads; when a queue is empty the head is junk.
  task automatic drive_fifos();
    sig_empty = (sig_q.size() == 0);
    ref_empty = (ref_q.size() == 0);
    cln_empty = (cln_q.size() == 0);
    {sig_ctx, sig_d} = sig_empty ? 7'($urandom) : sig_q[0];
    {ref_ctx, ref_d} = ref_empty ? 7'($urandom) : ref_q[0];
    {cln_ctx, cln_d} = cln_empty ? 7'($urandom) : cln_q[0];
  endtask

  // One clock cycle: sample at the falling edge, then apply pops just after the rising edge.
  task automatic tick();
    logic rs, rr, rc, bad;
    @(negedge clk);
    ready_s = plane_ready;
    flush_s = mq_flush;
    cur_s   = cur_pass;
    if (mq_init)     n_init++;
    if (mq_flush)    n_flush++;
    if (plane_ready) n_ready++;
    rs = sig_rd; rr = ref_rd; rc = cln_rd;
    if (rs | rr | rc) n_rd++;
    if (mq_en) got_q.push_back({mq_cx, mq_d});
    bad = (rs && sig_q.size() == 0) || (rr && ref_q.size() == 0) || (rc && cln_q.size() == 0)
       || (int'(rs) + int'(rr) + int'(rc) > 1) || (mq_en !== (rs | rr | rc))
       || (!mq_en && ({mq_cx, mq_d} !== 7'd0));
    check("fifo_mq_invariant", 32'(bad), 32'd0);
    @(posedge clk);
    #1;
    if (rs) void'(sig_q.pop_front());
    if (rr) void'(ref_q.pop_front());
    if (rc) void'(cln_q.pop_front());
    drive_fifos();
  endtask

  task automatic do_cblk(input bit with_go);
    cblk_start = 1'b1;
    plane_go   = with_go;
    last_plane = 1'($urandom);
    tick();
    cblk_start = 1'b0;
    plane_go   = 1'b0;
    pcnt_m     = 0;
    first_m    = 1'b1;
    check("mq_init_after_cblk", 32'(mq_init), 32'd1);
    check("pass_cnt_after_cblk", 32'(pass_cnt), 32'd0);
    check("err_after_cblk", 32'(err_overlap), 32'd0);
    check("idle_after_cblk", 32'(busy), 32'd0);
    tick();
    check("mq_init_one_cycle", 32'(mq_init), 32'd0);
  endtask

  // Run one plane. go_k injects a plane_go at that cycle of the plane.
  // abort_k aborts the plane at that cycle: mode 1 uses cblk_start, mode 2 uses rstn.
  task automatic run_plane(input int ns, input int nr, input int nc, input bit last,
                           input int go_k, input int abort_k, input int abort_mode);
    logic [6:0] exp_q[$];
    logic [6:0] v;
    int p, rdy_k, fl_k, fl0, rdy0, rd0, init0;
    bit first_e, aborted;
    first_e = first_m;
    got_q.delete();
    for (int i = 0; i < ns; i++) begin v = 7'($urandom); sig_q.push_back(v); exp_q.push_back(v); end
    for (int i = 0; i < nr; i++) begin v = 7'($urandom); ref_q.push_back(v); exp_q.push_back(v); end
    for (int i = 0; i < nc; i++) begin v = 7'($urandom); cln_q.push_back(v); exp_q.push_back(v); end
    drive_fifos();
    fl0 = n_flush;
    rdy0 = n_ready;
    plane_go   = 1'b1;
    last_plane = last;
    tick();
    plane_go = 1'b0;
    p = first_e ? nc + 1 : ns + nr + nc + 3;
    rdy_k = 0; fl_k = 0; aborted = 1'b0;
    for (int k = 1; k <= p + DRAIN_LAT + 2; k++) begin
      if (k == abort_k) begin aborted = 1'b1; break; end
      plane_go   = (k == go_k);
      last_plane = 1'($urandom);
      tick();
      plane_go = 1'b0;
      if (k == 1) check("cur_pass_entry", 32'(cur_s), first_e ? 32'd3 : 32'd1);
      if (flush_s && fl_k == 0) fl_k = k;
      if (ready_s) begin rdy_k = k; break; end
    end
    if (aborted) begin
      init0 = n_init;
      if (abort_mode == 1) begin
        cblk_start = 1'b1;
        tick();
        cblk_start = 1'b0;
      end else begin
        rstn = 1'b0;
        #1;
        check("outs_in_reset", 32'({mq_init, mq_en, mq_cx, mq_d, mq_flush, cur_pass, pass_cnt,
              plane_ready, busy, err_overlap, sig_rd, ref_rd, cln_rd}), 32'd0);
        rstn = 1'b1;
      end
      rd0 = n_rd;
      repeat (2 * DRAIN_LAT) tick();
      check("abort_no_ready", n_ready - rdy0, 0);
      check("abort_no_flush", n_flush - fl0, 0);
      check("abort_no_reads", n_rd - rd0, 0);
      check("abort_init", n_init - init0, (abort_mode == 1) ? 1 : 0);
      check("abort_pass_cnt", 32'(pass_cnt), 32'd0);
      check("abort_idle", 32'(busy), 32'd0);
      sig_q.delete(); ref_q.delete(); cln_q.delete();
      drive_fifos();
      pcnt_m  = 0;
      first_m = 1'b1;
    end else begin
      pcnt_m  = (pcnt_m + (first_e ? 1 : 3) > PASS_MAX) ? PASS_MAX : pcnt_m + (first_e ? 1 : 3);
      first_m = 1'b0;
      check("plane_ready_cycle", rdy_k, p + DRAIN_LAT);
      check("flush_cycle", fl_k, last ? p + 1 : 0);
      check("flush_count", n_flush - fl0, last ? 1 : 0);
      check("sym_count", got_q.size(), exp_q.size());
      foreach (exp_q[i]) check($sformatf("sym%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
      check("pass_cnt", 32'(pass_cnt), pcnt_m);
      check("idle_after_ready", 32'(busy), 32'd0);
    end
  endtask

  initial begin
    int init0, flush0;
    rstn = 1'b0; cblk_start = 1'b0; plane_go = 1'b0; last_plane = 1'b0;
    pcnt_m = 0; first_m = 1'b1;
    drive_fifos();
    repeat (2) tick();
    check("reset_outs", 32'({mq_init, mq_en, mq_cx, mq_d, mq_flush, cur_pass, pass_cnt,
          plane_ready, busy, err_overlap, sig_rd, ref_rd, cln_rd}), 32'd0);
    rstn = 1'b1;
    tick();

    // First plane (cleanup only), then a full plane, then an empty last plane
    do_cblk(1'b0);
    run_plane(0, 0, 5, 1'b0, 0, 0, 0);
    run_plane(3, 2, 4, 1'b0, 0, 0, 0);
    run_plane(0, 0, 0, 1'b1, 0, 0, 0);
    check("pass_cnt_three_planes", 32'(pass_cnt), 32'd7);

    // 4-plane codeblock with random contents
    init0 = n_init; flush0 = n_flush;
    do_cblk(1'b0);
    run_plane(0, 0, $urandom_range(0, 6), 1'b0, 0, 0, 0);
    run_plane($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 1'b0, 0, 0, 0);
    run_plane($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 1'b0, 0, 0, 0);
    run_plane($urandom_range(0, 5), $urandom_range(0, 5), $urandom_range(0, 5), 1'b1, 0, 0, 0);
    check("pass_cnt_4_planes", 32'(pass_cnt), 32'd10);
    check("one_flush_4_planes", n_flush - flush0, 1);
    check("one_init_4_planes", n_init - init0, 1);

    // plane_go during REF is ignored and sets the sticky error
    do_cblk(1'b0);
    run_plane(0, 0, 2, 1'b0, 0, 0, 0);
    run_plane(2, 3, 2, 1'b0, 5, 0, 0);
    check("err_overlap_set", 32'(err_overlap), 32'd1);
    run_plane(1, 1, 1, 1'b0, 0, 0, 0);
    check("err_overlap_sticky", 32'(err_overlap), 32'd1);
    do_cblk(1'b0);

    // cblk_start and plane_go together: plane_go dropped
    do_cblk(1'b1);

    // cblk_start during DRAIN, reset during SIG
    run_plane(0, 0, 1, 1'b0, 0, 0, 0);
    run_plane(1, 1, 1, 1'b0, 0, 9, 1);
    run_plane(0, 0, 2, 1'b0, 0, 0, 0);
    run_plane(4, 1, 1, 1'b1, 0, 2, 2);
    run_plane(0, 0, 2, 1'b0, 0, 0, 0);

    // Pass counter saturation
    do_cblk(1'b0);
    for (int i = 0; i < 90; i++)
      run_plane(first_m ? 0 : int'($urandom_range(0, 2)), first_m ? 0 : int'($urandom_range(0, 2)),
                int'($urandom_range(0, 2)), 1'b0, 0, 0, 0);
    check("pass_cnt_saturated", 32'(pass_cnt), 32'(PASS_MAX));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
